// File: rtl/bcd_rtc_clock_if.sv
// Control and time bus for the BCD real-time clock.
// Latency: none, this is wiring only.
// Backpressure: none, every signal is level or single-cycle pulse.
// Ports: master drives count enable, load request and alarm setup and observes the time.
//        slave is the clock core: it receives those controls and drives time and status.
interface bcd_rtc_clock_if;
    logic       ena;
    logic       load;
    logic [7:0] ld_hh;
    logic [7:0] ld_mm;
    logic [7:0] ld_ss;
    logic       ld_pm;
    logic       al_en;
    logic [7:0] al_hh;
    logic [7:0] al_mm;
    logic       al_pm;
    logic       al_clr;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       pm;
    logic       sec_tick;
    logic       alarm;
    logic       load_err;

    modport master (
        output ena, load, ld_hh, ld_mm, ld_ss, ld_pm,
        output al_en, al_hh, al_mm, al_pm, al_clr,
        input  hh, mm, ss, pm, sec_tick, alarm, load_err
    );

    modport slave (
        input  ena, load, ld_hh, ld_mm, ld_ss, ld_pm,
        input  al_en, al_hh, al_mm, al_pm, al_clr,
        output hh, mm, ss, pm, sec_tick, alarm, load_err
    );
endinterface

// File: rtl/bcd_rtc_clock.sv
// BCD hh:mm:ss real-time clock with seconds prescaler, 12/24h mode, checked load and sticky alarm.
// Latency: every output is registered; new time and sec_tick appear together one edge after the tick.
// Backpressure: none; ena freezes counting, a load request always overrides a coincident tick.
// Ports: clk rising-edge clock; reset asynchronous active-low;
//        bus (slave) carries ena/load/ld_*/al_* in and hh/mm/ss/pm/sec_tick/alarm/load_err out.
//        TICKS_PER_SEC (>=1) enabled cycles per second; MODE_24H selects 24-hour counting.
module bcd_rtc_clock #(
    parameter int TICKS_PER_SEC = 1,
    parameter bit MODE_24H      = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    bcd_rtc_clock_if.slave bus
);
    localparam int         PW       = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] CNT_MAX = PW'(TICKS_PER_SEC - 1);
    localparam logic [7:0] HH_RESET = MODE_24H ? 8'h00 : 8'h12;

    logic [PW-1:0] cnt;
    logic [7:0]    hh_q, mm_q, ss_q;
    logic          pm_q, tick_q, alarm_q, err_q;

    logic          tick;
    logic [7:0]    ss_n, mm_n, hh_n;
    logic          pm_n;
    logic          hr_carry;
    logic          ld_valid;
    logic          ld_pm_eff;
    logic          alarm_hit;

    // Units-first BCD increment; callers handle the digit-pair wrap points.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic nib_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    always_comb begin
        tick = bus.ena && (cnt == CNT_MAX);

        // Whole carry chain resolved in one cycle so no intermediate time is ever visible.
        ss_n     = (ss_q == 8'h59) ? 8'h00 : bcd_inc(ss_q);
        mm_n     = mm_q;
        hh_n     = hh_q;
        pm_n     = pm_q;
        hr_carry = (ss_q == 8'h59) && (mm_q == 8'h59);
        if (ss_q == 8'h59)
            mm_n = (mm_q == 8'h59) ? 8'h00 : bcd_inc(mm_q);
        if (hr_carry) begin
            if (MODE_24H) begin
                hh_n = (hh_q == 8'h23) ? 8'h00 : bcd_inc(hh_q);
            end else begin
                if (hh_q == 8'h12) begin
                    hh_n = 8'h01;
                end else begin
                    hh_n = bcd_inc(hh_q);
                    if (hh_q == 8'h11)
                        pm_n = ~pm_q;
                end
            end
        end
        if (MODE_24H)
            pm_n = (hh_n >= 8'h12);

        ld_valid = nib_ok(bus.ld_hh) && nib_ok(bus.ld_mm) && nib_ok(bus.ld_ss) &&
                   (bus.ld_mm <= 8'h59) && (bus.ld_ss <= 8'h59) &&
                   (MODE_24H ? (bus.ld_hh <= 8'h23)
                             : ((bus.ld_hh >= 8'h01) && (bus.ld_hh <= 8'h12)));
        ld_pm_eff = MODE_24H ? (bus.ld_hh >= 8'h12) : bus.ld_pm;

        // Only a real tick can raise the alarm; any load request swallows the tick.
        alarm_hit = tick && !bus.load && bus.al_en && (ss_n == 8'h00) &&
                    (hh_n == bus.al_hh) && (mm_n == bus.al_mm) &&
                    (MODE_24H || (pm_n == bus.al_pm));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            hh_q    <= HH_RESET;
            mm_q    <= 8'h00;
            ss_q    <= 8'h00;
            pm_q    <= 1'b0;
            tick_q  <= 1'b0;
            alarm_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            tick_q <= tick && !bus.load;
            err_q  <= bus.load && !ld_valid;

            if (bus.load) begin
                // A rejected load leaves time and prescaler exactly as they were.
                if (ld_valid) begin
                    cnt  <= '0;
                    hh_q <= bus.ld_hh;
                    mm_q <= bus.ld_mm;
                    ss_q <= bus.ld_ss;
                    pm_q <= ld_pm_eff;
                end
            end else if (bus.ena) begin
                if (tick) begin
                    cnt  <= '0;
                    hh_q <= hh_n;
                    mm_q <= mm_n;
                    ss_q <= ss_n;
                    pm_q <= pm_n;
                end else begin
                    cnt <= cnt + PW'(1);
                end
            end

            // Set takes priority over a simultaneous clear.
            if (alarm_hit)
                alarm_q <= 1'b1;
            else if (bus.al_clr)
                alarm_q <= 1'b0;
        end
    end

    assign bus.hh       = hh_q;
    assign bus.mm       = mm_q;
    assign bus.ss       = ss_q;
    assign bus.pm       = pm_q;
    assign bus.sec_tick = tick_q;
    assign bus.alarm    = alarm_q;
    assign bus.load_err = err_q;
endmodule

// File: doc/bcd_rtc_clock.md
# bcd_rtc_clock

Parametrised BCD real-time clock that succeeds the fixed 12-hour counter. It adds:
- a built-in seconds prescaler;
- compile-time 12/24-hour mode;
- validated synchronous time load;
- a sticky hh:mm alarm.

It sits under the display/top level and drives the BCD time digits directly.

## Interface
- TICKS_PER_SEC, 1: enabled clk cycles per second; must be ≥1 (1 = advance on every enabled cycle).
- MODE_24H, 0: 0 = 12-hour with pm flag, 1 = 24-hour.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- ena  input  1  count enable; low freezes prescaler and time.
- load  input  1  one-cycle request to load ld_hh/ld_mm/ld_ss/ld_pm.
- ld_hh, ld_mm, ld_ss  input  8 each  BCD load values.
- ld_pm  input  1  load pm; ignored when MODE_24H=1.
- al_en  input  1  alarm compare enable.
- al_hh, al_mm  input  8 each  BCD alarm time.
- al_pm  input  1  alarm pm; ignored when MODE_24H=1.
- al_clr  input  1  clears the alarm flag.
- hh, mm, ss  output  8 each  BCD time; tens digit in [7:4], units digit in [3:0].
- pm  output  1  12h: PM flag; 24h: high when hh ≥ 0x12.
- sec_tick  output  1  one-cycle pulse on each cycle the time advances.
- alarm  output  1  sticky alarm flag.
- load_err  output  1  one-cycle pulse when a load is rejected.

## Operation
- Reset values:
  - 12h mode: hh=0x12, mm=0x00, ss=0x00, pm=0.
  - 24h mode: hh=0x00, mm=0x00, ss=0x00, pm=0.
  - All modes: prescaler=0, sec_tick=0, alarm=0, load_err=0.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 while ena=1 and holds its value while ena=0.
  - A tick occurs on a cycle with ena=1 and count=TICKS_PER_SEC-1; count then returns to 0.
- On a tick, seconds advance in BCD: ss 0x59→0x00 with carry to mm; mm 0x59→0x00 with carry to hh.
- Hours in 12h mode on a carry:
  - 0x11→0x12 toggles pm.
  - 0x12→0x01.
  - 0x09→0x10.
  - All others +1.
- Hours in 24h mode on a carry: 0x09→0x10, 0x19→0x20, 0x23→0x00. pm is recomputed from the new hh.
- Load, when load=1:
  - Valid iff every nibble ≤ 9, mm ≤ 0x59 and ss ≤ 0x59.
  - 12h mode additionally requires 0x01 ≤ hh ≤ 0x12; 24h mode requires hh ≤ 0x23.
  - Valid load: takes effect on that edge and sets prescaler to 0.
  - Invalid load: no state change and load_err=1 for one cycle.
  - Load is honoured regardless of ena.
- Load beats tick: if load and a tick coincide, the load wins, the tick is discarded and sec_tick stays 0.
- Alarm set:
  - Sets on the edge where a tick produces ss=0x00 with hh=al_hh and mm=al_mm (plus pm=al_pm in 12h mode), while al_en=1.
  - Loads never set the alarm.
- Alarm clear: al_clr=1 clears the flag. If a set and a clear occur on the same edge, set wins.
- alarm stays high until it is cleared or reset.
- al_en=0 blocks new alarm sets but does not clear an existing flag.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- sec_tick asserts in the same cycle the new time appears on hh/mm/ss.
- Prescaler latency:
  - After reset, or after a valid load, the first tick occurs after TICKS_PER_SEC enabled cycles.
  - Disabled cycles do not count.
- A carry chain (e.g. 11:59:59 → 12:00:00) completes within the single tick edge; no intermediate values are ever visible.
- Reset asserted mid-count forces the reset values immediately (asynchronously). Counting resumes on the first rising edge after reset releases.
- load_err is high for exactly one cycle per rejected load. It is 0 in all other cycles, including cycles with a valid load.

## Test plan
- MODE_24H=0, TICKS_PER_SEC=1:
  - Step 1: release reset and hold ena=1 for 3 cycles → 12:00:03, pm=0.
  - Step 2: load 11:59:59 pm=0, then 1 tick → 12:00:00, pm=1.
  - Step 3: load 12:59:59, then 1 tick → 01:00:00 with pm unchanged.
- MODE_24H=1: load 23:59:59, then 1 tick → 00:00:00, pm=0. Load 11:59:59, then 1 tick → 12:00:00, pm=1.
- TICKS_PER_SEC=4, from reset:
  - sec_tick pulses every 4th enabled cycle.
  - Drop ena for 10 cycles mid-count → tick is delayed by exactly 10 cycles and the time is frozen meanwhile.
- Invalid loads, each → load_err pulse and time unchanged:
  - hh=0x13 in 12h mode;
  - hh=0x00 in 12h mode;
  - mm=0x60;
  - ss=0x5A.
  - Valid load asserted together with a tick → loaded value appears, sec_tick=0.
- Alarm, 12h mode:
  - al=07:30 pm=1, al_en=1; load 07:29:59 pm=1 → after 1 tick alarm=1, and it stays high over 100 further ticks.
  - al_clr together with a new match → alarm stays 1.
  - Loading exactly 07:30:00 does not set the alarm.
- Assert reset asynchronously mid-run at 05:42:17 → outputs show 12:00:00 pm=0, and alarm=0 and sec_tick=0, before the next clk edge.
